// File: rtl/mat_mul_pkg.sv
// Shared types and constants for the mat_mul matrix-vector engine.
package mat_mul_pkg;
   typedef enum logic [1:0] {IDLE, COMPUTE, SEND} state_t;

   localparam int ACC_WIDTH = 2*32 + 10;

   localparam logic SEL_WEIGHT = 1'b0;
   localparam logic SEL_INPUT  = 1'b1;

   // Array index width, never below one bit so single-entry memories stay legal.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/mat_mul_if.sv
// AXI4-Stream load (s00) and result (m00) channels of mat_mul.
interface mat_mul_if #(parameter int DATA_WIDTH = 32);
   logic [DATA_WIDTH-1:0]   s00_axis_tdata;
   logic                    s00_axis_tvalid;
   logic                    s00_axis_tlast;
   logic                    s00_axis_tready;
   logic [DATA_WIDTH-1:0]   m00_axis_tdata;
   logic                    m00_axis_tvalid;
   logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
   logic                    m00_axis_tlast;
   logic                    m00_axis_tready;

   modport slave (
      input  s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
      output s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tstrb, m00_axis_tlast
   );
   modport master (
      output s00_axis_tdata, s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
      input  s00_axis_tready, m00_axis_tdata, m00_axis_tvalid, m00_axis_tstrb, m00_axis_tlast
   );
endinterface

// File: rtl/mat_mul_mac.sv
// Signed multiply-accumulate with clear, plus the fixed-point shift/truncate stage.
module mac_unit
   import mat_mul_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_W      = ACC_WIDTH,
   parameter int FRAC       = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         clr,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] result
);
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]        acc;
   logic signed [ACC_W-1:0]        shifted;

   assign prod = a * b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= acc + ACC_W'(prod);
   end

   // Arithmetic shift floors toward -inf; upper bits simply wrap away.
   assign shifted = acc >>> FRAC;
   assign result  = shifted[DATA_WIDTH-1:0];
endmodule

// File: rtl/mat_mul.sv
// Streaming matrix-vector multiply: load weights/input over s00, start, stream results on m00.
module mat_mul
   import mat_mul_pkg::*;
#(
   parameter int INPUT_SIZE         = 10,
   parameter int RESULT_SIZE        = 1,
   parameter int WEIGHT_SIZE        = INPUT_SIZE*RESULT_SIZE,
   parameter int INPUT_ADDR_SIZE    = 10,
   parameter int RESULT_ADDR_SIZE   = 2,
   parameter int WEIGHT_ADDR_SIZE   = 10,
   parameter int FIXED_POINT_AMOUNT = 12,
   parameter int DATA_WIDTH         = 32
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   mat_mul_if.slave              axis,
   input  logic                  sel,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] MAC_result,
   output logic                  valid_MAC_result
);
   localparam int WI = idx_w(WEIGHT_SIZE);
   localparam int II = idx_w(INPUT_SIZE);
   localparam int RI = idx_w(RESULT_SIZE);
   localparam logic [WEIGHT_ADDR_SIZE-1:0] WP_W_SZ = WEIGHT_ADDR_SIZE'(WEIGHT_SIZE);
   localparam logic [WEIGHT_ADDR_SIZE-1:0] WP_I_SZ = WEIGHT_ADDR_SIZE'(INPUT_SIZE);
   localparam logic [INPUT_ADDR_SIZE-1:0]  COL_END = INPUT_ADDR_SIZE'(INPUT_SIZE);
   localparam logic [RESULT_ADDR_SIZE-1:0] ROW_END = RESULT_ADDR_SIZE'(RESULT_SIZE-1);

   logic signed [DATA_WIDTH-1:0] weight_mem [WEIGHT_SIZE];
   logic signed [DATA_WIDTH-1:0] input_mem  [INPUT_SIZE];
   logic signed [DATA_WIDTH-1:0] result_mem [RESULT_SIZE];

   state_t                      state, state_n;
   logic [WEIGHT_ADDR_SIZE-1:0] wptr, waddr;
   logic [INPUT_ADDR_SIZE-1:0]  col;
   logic [RESULT_ADDR_SIZE-1:0] row, oidx;
   logic                        tready_q, accept, wr_ok, mac_en, row_done, send_hs, last_out;
   logic signed [DATA_WIDTH-1:0] mac_res;

   assign accept   = (state == IDLE) && tready_q && axis.s00_axis_tvalid;
   assign wr_ok    = (sel == SEL_WEIGHT) ? (wptr < WP_W_SZ) : (wptr < WP_I_SZ);
   assign last_out = (state == SEND) && (oidx == ROW_END);
   assign send_hs  = (state == SEND) && axis.m00_axis_tready;

   assign axis.s00_axis_tready = tready_q;
   assign axis.m00_axis_tvalid = (state == SEND);
   assign axis.m00_axis_tlast  = last_out;
   assign axis.m00_axis_tstrb  = '1;
   assign axis.m00_axis_tdata  = (state == SEND) ? result_mem[oidx[RI-1:0]] : '0;

   always_comb begin
      state_n  = state;
      mac_en   = 1'b0;
      row_done = 1'b0;
      case (state)
         IDLE:    if (start) state_n = COMPUTE;
         COMPUTE: begin
            // Columns 0..N-1 accumulate; the extra cycle at col==N retires the row.
            if (col == COL_END) begin
               row_done = 1'b1;
               if (row == ROW_END) state_n = SEND;
            end else begin
               mac_en = 1'b1;
            end
         end
         SEND:    if (send_hs && last_out) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state            <= IDLE;
         tready_q         <= 1'b0;
         wptr             <= '0;
         waddr            <= '0;
         col              <= '0;
         row              <= '0;
         oidx             <= '0;
         MAC_result       <= '0;
         valid_MAC_result <= 1'b0;
      end else begin
         state            <= state_n;
         tready_q         <= (state_n == IDLE);
         valid_MAC_result <= 1'b0;
         if (accept) begin
            if (axis.s00_axis_tlast) wptr <= '0;
            else if (wr_ok)          wptr <= wptr + 1'b1;
         end
         if (state == IDLE) begin
            col   <= '0;
            row   <= '0;
            waddr <= '0;
            oidx  <= '0;
         end
         if (mac_en) begin
            col   <= col + 1'b1;
            waddr <= waddr + 1'b1;
         end
         if (row_done) begin
            col              <= '0;
            row              <= row + 1'b1;
            MAC_result       <= mac_res;
            valid_MAC_result <= 1'b1;
         end
         if (send_hs && !last_out) oidx <= oidx + 1'b1;
      end
   end

   // Memories are deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge s00_axi_aclk) begin
      if (accept && wr_ok) begin
         if (sel == SEL_INPUT) input_mem[wptr[II-1:0]]  <= axis.s00_axis_tdata;
         else                  weight_mem[wptr[WI-1:0]] <= axis.s00_axis_tdata;
      end
      if (row_done) result_mem[row[RI-1:0]] <= mac_res;
   end

   mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (2*DATA_WIDTH + INPUT_ADDR_SIZE),
      .FRAC       (FIXED_POINT_AMOUNT)
   ) u_mac (
      .clk    (s00_axi_aclk),
      .rst_n  (s00_axi_aresetn),
      .en     (mac_en),
      .clr    (row_done || (state == IDLE)),
      .a      (weight_mem[waddr[WI-1:0]]),
      .b      (input_mem[col[II-1:0]]),
      .result (mac_res)
   );
endmodule

// File: tb/tb_mat_mul.sv
// Directed + randomized bench for mat_mul with a 3-row layer and an arithmetic reference model.
module tb_mat_mul;
   localparam int IS = 10;
   localparam int RS = 3;
   localparam int WS = IS*RS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   logic start = 1'b0;
   logic [31:0] MAC_result;
   logic        valid_MAC_result;

   mat_mul_if #(.DATA_WIDTH(32)) ax ();

   mat_mul #(.INPUT_SIZE(IS), .RESULT_SIZE(RS), .WEIGHT_SIZE(WS)) dut (
      .s00_axi_aclk     (clk),
      .s00_axi_aresetn  (rst_n),
      .axis             (ax),
      .sel              (sel),
      .start            (start),
      .MAC_result       (MAC_result),
      .valid_MAC_result (valid_MAC_result)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic signed [31:0] wm [WS];
   logic signed [31:0] im [IS];
   logic signed [31:0] wbuf [64];
   logic [31:0] expv [RS];
   logic [31:0] out_data [RS];
   logic        out_last [RS];
   logic [31:0] mac_q [$];
   int          got;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic signed [31:0] rnd();
      return $signed(32'($urandom_range(0, 2**21))) - 32'sd1048576;
   endfunction

   // Reference: plain dot product in wide integers, then floor-divide by 2^12.
   function automatic logic [31:0] ref_row(input int r);
      logic signed [127:0] s;
      logic signed [127:0] t;
      s = 0;
      for (int i = 0; i < IS; i++) s = s + wm[r*IS+i] * im[i];
      t = s >>> 12;
      return t[31:0];
   endfunction

   task automatic load(input logic s, input int n);
      int wait_c;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sel = s;
         ax.s00_axis_tdata  = wbuf[i];
         ax.s00_axis_tvalid = 1'b1;
         ax.s00_axis_tlast  = (i == n-1);
         wait_c = 0;
         while (!ax.s00_axis_tready && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
         end
         if (wait_c >= 20) chk("load_tready_timeout", 32'(wait_c), 32'd0);
         if (s == 1'b0 && i < WS) wm[i] = wbuf[i];
         if (s == 1'b1 && i < IS) im[i] = wbuf[i];
      end
      @(negedge clk);
      ax.s00_axis_tvalid = 1'b0;
      ax.s00_axis_tlast  = 1'b0;
   endtask

   task automatic run(input string tag, input int bp);
      got = 0;
      mac_q.delete();
      for (int r = 0; r < RS; r++) expv[r] = ref_row(r);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 400 && got < RS; c++) begin
         if (valid_MAC_result) mac_q.push_back(MAC_result);
         case (bp)
            0:       ax.m00_axis_tready = 1'b1;
            1:       ax.m00_axis_tready = (c % 2 == 0);
            default: ax.m00_axis_tready = 1'($urandom_range(0, 1));
         endcase
         if (ax.m00_axis_tvalid && ax.m00_axis_tready) begin
            out_data[got] = ax.m00_axis_tdata;
            out_last[got] = ax.m00_axis_tlast;
            got++;
         end
         @(negedge clk);
      end
      ax.m00_axis_tready = 1'b0;
      chk({tag, "_count"}, 32'(got), 32'(RS));
      chk({tag, "_mac_pulses"}, 32'(mac_q.size()), 32'(RS));
      for (int r = 0; r < got; r++) begin
         chk($sformatf("%s_data%0d", tag, r), out_data[r], expv[r]);
         chk($sformatf("%s_last%0d", tag, r), 32'(out_last[r]), 32'(r == RS-1));
         if (r < mac_q.size()) chk($sformatf("%s_mac%0d", tag, r), mac_q[r], expv[r]);
      end
      chk({tag, "_idle_tvalid"}, 32'(ax.m00_axis_tvalid), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_tready"}, 32'(ax.s00_axis_tready), 32'd0);
      chk({tag, "_m_tvalid"}, 32'(ax.m00_axis_tvalid), 32'd0);
      chk({tag, "_m_tdata"},  ax.m00_axis_tdata, 32'd0);
      chk({tag, "_m_tlast"},  32'(ax.m00_axis_tlast), 32'd0);
      chk({tag, "_m_tstrb"},  32'(ax.m00_axis_tstrb), 32'hF);
      chk({tag, "_mac"},      MAC_result, 32'd0);
      chk({tag, "_mac_vld"},  32'(valid_MAC_result), 32'd0);
   endtask

   initial begin
      ax.s00_axis_tdata  = '0;
      ax.s00_axis_tvalid = 1'b0;
      ax.s00_axis_tlast  = 1'b0;
      ax.m00_axis_tready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_reset_tready", 32'(ax.s00_axis_tready), 32'd1);

      // Spec vector in row 0, random rows 1..2
      wbuf[0] = 999999; wbuf[1] = 99999; wbuf[2] = -631; wbuf[3] = 6241; wbuf[4] = 2930;
      wbuf[5] = 1705;   wbuf[6] = -7018; wbuf[7] = 207;   wbuf[8] = -1440; wbuf[9] = 2801;
      for (int i = IS; i < WS; i++) wbuf[i] = rnd();
      load(1'b0, WS);
      for (int i = 0; i < IS; i++) wbuf[i] = (i < 2) ? 32'sd1 : 32'sd0;
      load(1'b1, IS);
      run("spec", 0);
      chk("spec_row0_const", out_data[0], 32'd268);

      // Reuse weights with a new input only
      for (int i = 0; i < IS; i++) wbuf[i] = (i == 2) ? 32'sd4096 : 32'sd0;
      load(1'b1, IS);
      run("reuse", 0);
      chk("reuse_row0_const", out_data[0], 32'hFFFF_FD89);

      // Negative floor: -1 >>> 12 stays -1
      for (int i = 0; i < WS; i++) wbuf[i] = -32'sd1;
      load(1'b0, WS);
      for (int i = 0; i < IS; i++) wbuf[i] = (i == 0) ? 32'sd1 : 32'sd0;
      load(1'b1, IS);
      run("negfloor", 0);
      chk("negfloor_const", out_data[RS-1], 32'hFFFF_FFFF);

      // Backpressure: rows scaled 1,2,3 -> 10,20,30
      for (int i = 0; i < WS; i++) wbuf[i] = 32'sd4096 * ((i / IS) + 1);
      load(1'b0, WS);
      for (int i = 0; i < IS; i++) wbuf[i] = 32'sd1;
      load(1'b1, IS);
      run("bp", 1);
      chk("bp_row2_const", out_data[2], 32'd30);

      // Reset two cycles into COMPUTE
      for (int i = 0; i < IS; i++) wbuf[i] = rnd();
      load(1'b1, IS);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("midreset_tready", 32'(ax.s00_axis_tready), 32'd1);
      run("after_reset", 0);

      // Load overflow: 32 weight words, last two dropped, next input load starts at 0
      for (int i = 0; i < WS+2; i++) wbuf[i] = rnd();
      load(1'b0, WS+2);
      for (int i = 0; i < IS; i++) wbuf[i] = rnd();
      load(1'b1, IS);
      run("overflow", 0);

      // Randomized rounds with random backpressure
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < WS; i++) wbuf[i] = rnd();
         load(1'b0, WS);
         for (int i = 0; i < IS; i++) wbuf[i] = rnd();
         load(1'b1, IS);
         run($sformatf("rand%0d", k), 2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
